// File: rtl/gshare_predictor.sv
// Fetch-stage direction predictor: table of saturating counters indexed bimodally or gshare-style,
// with a speculative global history register, checkpoint recovery and a post-reset init sweep.
module gshare_predictor #(
   parameter int FETCH_W = 2,
   parameter int ABITS   = 10,
   parameter int HBITS   = 8,
   parameter int CBITS   = 2,
   parameter int HASH    = 1
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               we_i,
   input  logic [31:0]        pc_i,
   output logic [FETCH_W-1:0] pred_o,
   output logic [HBITS-1:0]   hist_o,
   output logic               ready_o,
   input  logic               spec_valid_i,
   input  logic               spec_taken_i,
   input  logic               upd_valid_i,
   input  logic [31:0]        upd_pc_i,
   input  logic [HBITS-1:0]   upd_hist_i,
   input  logic               upd_taken_i,
   input  logic               recover_i,
   input  logic [HBITS-1:0]   recover_hist_i
);

   localparam int DEPTH = 1 << ABITS;
   localparam logic [CBITS-1:0] WEAK_NT = CBITS'((1 << (CBITS - 1)) - 1);
   localparam logic [CBITS-1:0] CTR_MAX = '1;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [ABITS-1:0] ptr_q, ptr_d;
   logic [HBITS-1:0] ghr_q, ghr_d, ghr_shift;
   logic [HBITS-1:0] hist_q;
   logic [ABITS-1:0] base_q;

   logic [CBITS-1:0] ctr_mem [DEPTH];

   logic             tbl_we;
   logic [ABITS-1:0] tbl_waddr;
   logic [CBITS-1:0] tbl_wdata;

   logic [ABITS-1:0] upd_idx;
   logic [CBITS-1:0] upd_ctr, upd_next;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_i[31:ABITS+2], pc_i[1:0], upd_pc_i[31:ABITS+2], upd_pc_i[1:0]};

   // Slot offset wraps at the table top before the history is folded in.
   function automatic logic [ABITS-1:0] index_f(input logic [ABITS-1:0] base,
                                                input logic [HBITS-1:0] hist,
                                                input logic [ABITS-1:0] slot);
      logic [ABITS-1:0] idx;
      idx = base + slot;
      if (HASH != 0) idx = idx ^ ABITS'(hist);
      return idx;
   endfunction

   generate
      if (HBITS == 1) begin : g_ghr1
         assign ghr_shift = spec_taken_i;
      end else begin : g_ghrn
         assign ghr_shift = {ghr_q[HBITS-2:0], spec_taken_i};
      end
   endgenerate

   assign upd_idx = index_f(upd_pc_i[ABITS+1:2], upd_hist_i, '0);
   assign upd_ctr = ctr_mem[upd_idx];

   always_comb begin
      upd_next = upd_ctr;
      if (upd_taken_i && upd_ctr != CTR_MAX) upd_next = upd_ctr + CBITS'(1);
      else if (!upd_taken_i && upd_ctr != '0) upd_next = upd_ctr - CBITS'(1);
   end

   // Next-state / table write port: the sweep owns the port until RUN.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      ghr_d     = ghr_q;
      tbl_we    = 1'b0;
      tbl_waddr = '0;
      tbl_wdata = '0;
      case (state_q)
         ST_INIT: begin
            tbl_we    = 1'b1;
            tbl_waddr = ptr_q;
            tbl_wdata = WEAK_NT;
            ptr_d     = ptr_q + ABITS'(1);
            if (ptr_q == '1) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (upd_valid_i) begin
               tbl_we    = 1'b1;
               tbl_waddr = upd_idx;
               tbl_wdata = upd_next;
            end
            if (recover_i) ghr_d = recover_hist_i;
            else if (spec_valid_i && we_i) ghr_d = ghr_shift;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         ghr_q   <= '0;
         base_q  <= '0;
         hist_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ghr_q   <= ghr_d;
         if (state_q == ST_RUN && we_i) begin
            base_q <= pc_i[ABITS+1:2];
            hist_q <= ghr_q;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (tbl_we) ctr_mem[tbl_waddr] <= tbl_wdata;
   end

   generate
      for (genvar k = 0; k < FETCH_W; k++) begin : g_slot
         logic [CBITS-1:0] slot_ctr;
         assign slot_ctr  = ctr_mem[index_f(base_q, hist_q, ABITS'(k))];
         assign pred_o[k] = (state_q == ST_RUN) && slot_ctr[CBITS-1];
      end
   endgenerate

   assign hist_o  = hist_q;
   assign ready_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (ABITS=4, HBITS=4, FETCH_W=2, CBITS=2, gshare hashing)
// against a behavioural counter-table model.
module tb_gshare_predictor;

   localparam int FW    = 2;
   localparam int AB    = 4;
   localparam int HB    = 4;
   localparam int CB    = 2;
   localparam int DEPTH = 16;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          we_i, spec_valid_i, spec_taken_i, upd_valid_i, upd_taken_i, recover_i;
   logic [31:0]   pc_i, upd_pc_i;
   logic [HB-1:0] upd_hist_i, recover_hist_i;
   logic [FW-1:0] pred_o;
   logic [HB-1:0] hist_o;
   logic          ready_o;

   gshare_predictor #(.FETCH_W(FW), .ABITS(AB), .HBITS(HB), .CBITS(CB), .HASH(1)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .we_i(we_i), .pc_i(pc_i),
      .pred_o(pred_o), .hist_o(hist_o), .ready_o(ready_o),
      .spec_valid_i(spec_valid_i), .spec_taken_i(spec_taken_i),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_hist_i(upd_hist_i),
      .upd_taken_i(upd_taken_i), .recover_i(recover_i), .recover_hist_i(recover_hist_i)
   );

   always #5 clock_i = ~clock_i;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: counters as integers, history as an integer shift value.
   int          m_ctr [DEPTH];
   bit          m_ready;
   int          m_ptr;
   int unsigned m_pc;
   int          m_hist;
   int          m_ghr;

   function automatic int model_index(int unsigned pc, int hist, int slot);
      return (((pc / 4) + slot) % DEPTH) ^ (hist % DEPTH);
   endfunction

   function automatic logic [FW-1:0] expected_pred();
      logic [FW-1:0] p;
      for (int k = 0; k < FW; k++)
         p[k] = m_ready && (m_ctr[model_index(m_pc, m_hist, k)] >= 2);
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
      m_ready = 0; m_ptr = 0; m_pc = 0; m_hist = 0; m_ghr = 0;
   endtask

   task automatic model_step();
      int idx, old_ghr;
      if (!m_ready) begin
         m_ptr++;
         if (m_ptr == DEPTH) m_ready = 1;
      end else begin
         if (upd_valid_i) begin
            idx = model_index(upd_pc_i, int'(upd_hist_i), 0);
            if (upd_taken_i && m_ctr[idx] < 3) m_ctr[idx]++;
            else if (!upd_taken_i && m_ctr[idx] > 0) m_ctr[idx]--;
         end
         old_ghr = m_ghr;
         if (recover_i) m_ghr = int'(recover_hist_i);
         else if (spec_valid_i && we_i) m_ghr = (m_ghr * 2 + int'(spec_taken_i)) % DEPTH;
         if (we_i) begin
            m_pc   = pc_i;
            m_hist = old_ghr;
         end
      end
   endtask

   task automatic idle_inputs();
      we_i = 0; pc_i = 0; spec_valid_i = 0; spec_taken_i = 0;
      upd_valid_i = 0; upd_pc_i = 0; upd_hist_i = 0; upd_taken_i = 0;
      recover_i = 0; recover_hist_i = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic apply_reset(input string tag);
      idle_inputs();
      @(posedge clock_i);
      #2;
      reset_i = 1;
      #1;
      tests_run++;
      if (ready_o !== 1'b0 || pred_o !== '0 || hist_o !== '0) begin
         tests_failed++;
         $display("FAIL %s_async ready/pred/hist got %b/%b/%b expected 0/00/0000", tag, ready_o, pred_o, hist_o);
      end
      model_reset();
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      reset_i = 0;
   endtask

   // Sweep with random (ignored) traffic; ready must rise exactly on the 16th edge.
   task automatic run_sweep(input string tag);
      for (int c = 1; c <= DEPTH; c++) begin
         we_i = 1'($urandom_range(0, 1)); pc_i = $urandom;
         upd_valid_i = 1'($urandom_range(0, 1)); upd_pc_i = $urandom;
         upd_taken_i = 1'($urandom_range(0, 1)); upd_hist_i = 4'($urandom);
         spec_valid_i = 1'($urandom_range(0, 1)); spec_taken_i = 1'($urandom_range(0, 1));
         recover_i = 1'($urandom_range(0, 1)); recover_hist_i = 4'($urandom);
         tick();
         tests_run++;
         if (ready_o !== m_ready || ready_o !== (c == DEPTH)) begin
            tests_failed++;
            $display("FAIL %s_ready cycle %0d got %b expected %b", tag, c, ready_o, c == DEPTH);
         end
         if (c < DEPTH) begin
            tests_run++;
            if (pred_o !== '0 || hist_o !== '0) begin
               tests_failed++;
               $display("FAIL %s_init_out cycle %0d pred %b hist %b expected 00 0000", tag, c, pred_o, hist_o);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic scan_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         we_i = 1; pc_i = 32'(i * 4) | ($urandom & 32'hFFFF_FFC0);
         tick();
         tests_run++;
         if (pred_o !== expected_pred() || pred_o !== 2'b00 || hist_o !== 4'(m_hist)) begin
            tests_failed++;
            $display("FAIL %s_scan entry %0d pred %b hist %h expected 00 %h", tag, i, pred_o, hist_o, 4'(m_hist));
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      apply_reset("reset");
      run_sweep("reset");
      scan_all("reset");
   endtask

   task automatic test_saturation();
      logic [FW-1:0] exp_seq [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      we_i = 1; pc_i = 32'h40;
      tick();
      we_i = 0;
      for (int n = 0; n < 9; n++) begin
         upd_valid_i = 1; upd_pc_i = 32'h40; upd_hist_i = 0;
         upd_taken_i = (n < 4);
         tick();
         tests_run++;
         if (pred_o !== expected_pred() || pred_o !== exp_seq[n]) begin
            tests_failed++;
            $display("FAIL sat step %0d pred got %b expected %b", n, pred_o, exp_seq[n]);
         end
      end
      // Counter sits at 0; one taken must read weak-not-taken, not wrap to strong.
      upd_taken_i = 1;
      tick();
      upd_valid_i = 0;
      tick();
      tests_run++;
      if (pred_o !== expected_pred() || pred_o !== 2'b00) begin
         tests_failed++;
         $display("FAIL sat_nowrap pred got %b expected 00", pred_o);
      end
      idle_inputs();
   endtask

   task automatic test_slot_wrap();
      upd_valid_i = 1; upd_pc_i = 32'h0; upd_hist_i = 0; upd_taken_i = 1;
      repeat (2) tick();
      upd_valid_i = 0; we_i = 1; pc_i = 32'h3C;
      tick();
      tests_run++;
      if (pred_o !== expected_pred() || pred_o !== 2'b10) begin
         tests_failed++;
         $display("FAIL slot_wrap pred got %b expected 10", pred_o);
      end
      idle_inputs();
   endtask

   task automatic test_recover();
      logic [HB-1:0] exp_h [2] = '{4'b0101, 4'b0011};
      int pushes [3] = '{1, 0, 1};
      for (int n = 0; n < 3; n++) begin
         we_i = 1; pc_i = 32'h100; spec_valid_i = 1; spec_taken_i = 1'(pushes[n]);
         tick();
      end
      recover_i = 1; recover_hist_i = 4'b0011; spec_valid_i = 1; spec_taken_i = 1;
      tick();
      recover_i = 0; spec_valid_i = 0;
      for (int n = 0; n < 2; n++) begin
         if (n == 1) tick();
         tests_run++;
         if (hist_o !== 4'(m_hist) || hist_o !== exp_h[n] || pred_o !== expected_pred()) begin
            tests_failed++;
            $display("FAIL recover step %0d hist got %b expected %b pred %b/%b", n, hist_o, exp_h[n], pred_o, expected_pred());
         end
      end
      idle_inputs();
   endtask

   task automatic test_stall();
      logic [HB-1:0] held_h;
      we_i = 1; pc_i = 32'h80;
      tick();
      held_h = hist_o;
      we_i = 0;
      for (int n = 0; n < 3; n++) begin
         pc_i = $urandom; spec_valid_i = 1; spec_taken_i = 1;
         upd_valid_i = 1; upd_pc_i = 32'h80; upd_hist_i = held_h; upd_taken_i = 1;
         tick();
         tests_run++;
         if (pred_o !== expected_pred() || hist_o !== held_h || hist_o !== 4'(m_hist)) begin
            tests_failed++;
            $display("FAIL stall step %0d pred %b hist %b expected %b %b", n, pred_o, hist_o, expected_pred(), held_h);
         end
      end
      idle_inputs();
      we_i = 1; pc_i = 32'h80;
      tick();
      tests_run++;
      if (hist_o !== 4'(m_hist) || pred_o !== expected_pred() || pred_o[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_ghr hist %b pred %b expected %b %b", hist_o, pred_o, 4'(m_hist), expected_pred());
      end
      idle_inputs();
   endtask

   task automatic test_random(input int cycles, input string tag);
      for (int n = 0; n < cycles; n++) begin
         we_i = 1'($urandom_range(0, 3) != 0); pc_i = $urandom;
         spec_valid_i = 1'($urandom_range(0, 1)); spec_taken_i = 1'($urandom_range(0, 1));
         upd_valid_i = 1'($urandom_range(0, 2) != 0); upd_pc_i = $urandom;
         upd_hist_i = 4'($urandom); upd_taken_i = 1'($urandom_range(0, 1));
         recover_i = 1'($urandom_range(0, 7) == 0); recover_hist_i = 4'($urandom);
         tick();
         tests_run++;
         if (pred_o !== expected_pred() || hist_o !== 4'(m_hist) || ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s cycle %0d pred %b hist %b ready %b expected %b %b 1", tag, n, pred_o, hist_o, ready_o, expected_pred(), 4'(m_hist));
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset("mid_sweep");
      repeat (7) tick();
      apply_reset("mid_sweep2");
      run_sweep("mid_sweep");
      test_random(60, "train");
      apply_reset("mid_run");
      run_sweep("mid_run");
      scan_all("mid_run");
   endtask

   initial begin
      idle_inputs();
      model_reset();
      test_reset();
      test_saturation();
      test_slot_wrap();
      test_recover();
      test_stall();
      test_random(300, "random");
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
